// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one partial product per clock, WIDTH iterations,
// signed mode handled by subtracting the final (sign-weighted) row.
module seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   acc;
    logic [PW-1:0]   acc_next;
    logic [PW-1:0]   mcand;
    logic [WIDTH-1:0] mplier;
    logic            sgn;
    logic            last_c;

    assign last_c = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_c) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The top multiplier bit carries weight -2^(W-1) in signed mode, so that row is subtracted.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            if (sgn && last_c) begin
                acc_next = acc - mcand;
            end else begin
                acc_next = acc + mcand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sgn    <= 1'b0;
            p      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= is_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        sgn    <= is_signed;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (last_c) begin
                        p <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            done <= (state_next == DONE);
        end
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to begin a multiply; sampled on clk rising edge.
REQ-005 is_signed  input  1  1 = two's-complement operands; 0 = unsigned operands.
REQ-006 a  input  WIDTH  multiplicand.
REQ-007 b  input  WIDTH  multiplier.
REQ-008 busy  output  1  high whenever the block is not IDLE.
REQ-009 done  output  1  one-cycle pulse; p is valid in that cycle.
REQ-010 p  output  2*WIDTH  product; held until the next accepted start.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-012 IDLE -> CALC on an edge with start=1; a, b and is_signed SHALL be captured on that edge, and the iteration counter SHALL be set to 0.
REQ-013 CALC SHALL perform one partial-product iteration per edge and SHALL last exactly WIDTH edges; the WIDTH-th iteration edge SHALL enter DONE and load p.
REQ-014 DONE -> IDLE unconditionally on the next edge; done=1 only in DONE.
REQ-015 Latency: if start is accepted at edge k, then done=1 and p is valid in the cycle following edge k+WIDTH.
REQ-016 busy SHALL be 1 in CALC and DONE, and 0 in IDLE.
REQ-017 start SHALL be ignored in CALC and DONE; no queuing, and captured operands are unaffected.
REQ-018 Back-to-back operation: start=1 in the first IDLE cycle after DONE SHALL be accepted, giving a minimum issue interval of WIDTH+2 cycles.
REQ-019 Changes to a, b or is_signed after capture SHALL have no effect on the running operation.
REQ-020 Signed mode: p SHALL equal the exact 2*WIDTH-bit two's-complement product, including (-2^(W-1))*(-2^(W-1)) = +2^(2W-2).
REQ-021 Unsigned mode: p SHALL equal the exact 2*WIDTH-bit unsigned product; no overflow is possible.
REQ-022 The internal algorithm (shift-add with final-row correction, or radix-2 Booth) is free, provided REQ-013/015/020/021 hold bit-exactly for all operand pairs.
REQ-023 p SHALL change only on the edge entering DONE, and SHALL otherwise hold its value, including through IDLE and CALC.
REQ-024 The RTL SHALL be synthesizable and SHALL contain no combinational multiply operator on the full operand width.

Reset
REQ-025 When rst=1, the block SHALL immediately, without a clock edge, set state=IDLE, busy=0, done=0, p=0, and clear counter and operand registers.
REQ-026 Reset asserted in CALC or DONE SHALL abort the operation; no done pulse SHALL follow.
REQ-027 The first edge after rst deasserts SHALL accept start normally.

Verification
REQ-028 WIDTH=4, is_signed=1, a=4'b1000, b=4'b1000, start at edge k -> done at cycle after edge k+4, p=8'h40.
REQ-029 WIDTH=4, is_signed=0, a=4'hF, b=4'hF -> p=8'hE1; is_signed=1, a=4'hF, b=4'h7 -> p=8'hF9.
REQ-030 WIDTH=8, is_signed=1, a=8'h80, b=8'h7F -> p=16'hC080; the same operands with is_signed=0 -> p=16'h3F80.
REQ-031 start pulsed and a changed during CALC -> a single done pulse at the original time with the original product; busy stays high for exactly WIDTH+1 cycles.
REQ-032 rst asserted at iteration 2 of CALC -> busy, done and p go to 0 immediately, no done pulse follows, and the next start yields a correct product.
REQ-033 Exhaustive run, WIDTH=4, both modes, all 256 operand pairs with back-to-back starts -> every p matches the reference model, with issue interval 6 cycles.
